// File: rtl/lcd_sched_pkg.sv
// lcd_sched_pkg: shared state encoding, view codes and requester indices for the LCD view scheduler.
package lcd_sched_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_OLD, WAIT_NEW} state_t;
  localparam logic [2:0] VIEW_TIME = 3'b000;
  localparam logic [2:0] VIEW_UP = 3'b100;
  localparam logic [2:0] VIEW_DOWN_HM = 3'b110;
  localparam logic [2:0] VIEW_DOWN_S = 3'b111;
  localparam logic [1:0] REQ_TIME = 2'd0;
  localparam logic [1:0] REQ_UP = 2'd1;
  localparam logic [1:0] REQ_DOWN = 2'd2;
  function automatic logic [1:0] nxt3(input logic [1:0] i);
    return (i >= REQ_DOWN) ? REQ_TIME : i + 2'd1;
  endfunction
  function automatic logic [1:0] idx_of(input logic [2:0] g);
    return g[2] ? REQ_DOWN : g[1] ? REQ_UP : REQ_TIME;
  endfunction
  function automatic logic [2:0] view_of(input logic [1:0] i, input logic s);
    return (i == REQ_DOWN) ? (s ? VIEW_DOWN_S : VIEW_DOWN_HM) : (i == REQ_UP) ? VIEW_UP : VIEW_TIME;
  endfunction
endpackage

// File: rtl/lcd_view_sched_rr_arb3.sv
// rr_arb3: combinational round-robin pick among three requesters, searching from the one after rr_ptr.
module rr_arb3
  import lcd_sched_pkg::*;
(
  input  logic [2:0] pending,
  input  logic [1:0] rr_ptr,
  output logic [1:0] idx,
  output logic       valid,
  output logic [2:0] onehot
);
  logic [1:0] c1, c2;
  always_comb begin
    c1 = nxt3(rr_ptr);
    c2 = nxt3(c1);
    idx = pending[c1] ? c1 : pending[c2] ? c2 : nxt3(c2);
    valid = |pending;
    onehot = valid ? 3'b001 << idx : 3'b000;
  end
endmodule

// File: rtl/lcd_view_sched.sv
// lcd_view_sched: arbitrates LCD redraw requests, latches the winning view and tracks the two frames
// until the new image is shown; adds idle self-refresh and a stall timeout.
module lcd_view_sched
  import lcd_sched_pkg::*;
#(
  parameter logic [23:0] REFRESH_CYC = 24'd500000,
  parameter logic [23:0] TIMEOUT_CYC = 24'd2000000
) (
  input  logic       clk_div,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic       req_show,
  input  logic       frame_done,
  output logic       change,
  output logic       time_or_watch,
  output logic       mode,
  output logic       show,
  output logic [2:0] grant,
  output logic       busy,
  output logic       timeout_err
);
  state_t state;
  logic [2:0] pending, clr, w_one;
  logic [1:0] rr_ptr, w_idx;
  logic w_valid, refresh_due, fin, tmo;
  logic [23:0] ref_cnt, to_cnt;
  rr_arb3 u_arb (.pending(pending), .rr_ptr(rr_ptr), .idx(w_idx), .valid(w_valid), .onehot(w_one));
  always_comb begin
    fin = (state == WAIT_NEW) && frame_done;
    tmo = (state == WAIT_OLD || state == WAIT_NEW) && !frame_done && to_cnt == TIMEOUT_CYC - 24'd1;
    clr = (fin || tmo) ? grant : 3'b000;
  end
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pending <= 3'b000;
      rr_ptr <= REQ_DOWN;
      ref_cnt <= '0;
      to_cnt <= '0;
      refresh_due <= 1'b0;
      change <= 1'b0;
      {time_or_watch, mode, show} <= VIEW_TIME;
      grant <= 3'b000;
      busy <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | req;
      change <= 1'b0;
      case (state)
        IDLE: begin
          if (ref_cnt == REFRESH_CYC - 24'd1) refresh_due <= 1'b1;
          else ref_cnt <= ref_cnt + 24'd1;
          if (w_valid) begin
            grant <= w_one;
            {time_or_watch, mode, show} <= view_of(w_idx, req_show);
            change <= 1'b1;
            busy <= 1'b1;
            state <= ISSUE;
          end else if (refresh_due) begin
            change <= 1'b1;
            busy <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          ref_cnt <= '0;
          refresh_due <= 1'b0;
          to_cnt <= '0;
          state <= WAIT_OLD;
        end
        default: begin
          if (frame_done && state == WAIT_OLD) begin
            to_cnt <= '0;
            state <= WAIT_NEW;
          end else if (fin || tmo) begin
            if (fin && grant != 3'b000) rr_ptr <= idx_of(grant);
            if (tmo) timeout_err <= 1'b1;
            grant <= 3'b000;
            busy <= 1'b0;
            state <= IDLE;
          end else to_cnt <= to_cnt + 24'd1;
        end
      endcase
    end
  end
endmodule
